// File: rtl/multicycle_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_core_ctrl
// Purpose  : Multi-cycle FETCH/DECODE/EXECUTE/MEM/WB sequencer for the RV32
//            NPC core. Owns the PC and instruction register and talks to
//            instruction/data memory over valid/ready handshakes with a
//            wait-state timeout.
// Options  : MC_CTRL_PERF_EN adds perf_cycles / perf_instret counters.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_core_ctrl #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000,
  parameter int                MAX_WAIT = 255
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] pc,
  input  logic              dec_is_load,
  input  logic              dec_is_store,
  input  logic              dec_reg_write,
  input  logic              dec_ebreak,
  input  logic [ADDR_W-1:0] ex_next_pc,
  input  logic [ADDR_W-1:0] ex_mem_addr,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  input  logic              dmem_ready,
  input  logic [31:0]       dmem_rdata,
  output logic [31:0]       load_data,
  output logic              rf_wen,
  output logic [2:0]        state,
  output logic              halted,
  output logic [1:0]        err_code
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [63:0]       perf_cycles,
  output logic [63:0]       perf_instret
`endif
);

  localparam int                WAIT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] C_MAX_WAIT = WAIT_W'(MAX_WAIT);

  localparam logic [1:0] C_ERR_NONE    = 2'd0;
  localparam logic [1:0] C_ERR_TIMEOUT = 2'd1;
  localparam logic [1:0] C_ERR_MISALGN = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic [31:0]         r_inst;
  logic [ADDR_W-1:0]   r_dmem_addr;
  logic [31:0]         r_load_data;
  logic                r_halted;
  logic [1:0]          r_err_code;
  logic [WAIT_W-1:0]   r_wait_cnt;

  logic w_mem_wait;
  logic w_timeout;
  logic w_misaligned;

  // Requests are decoded straight from the state so they drop the same cycle
  // reset is raised and stay stable while a transfer is pending.
  assign imem_req  = (r_state == S_FETCH) & ~rst;
  assign imem_addr = r_pc;
  assign dmem_req  = (r_state == S_MEM) & ~rst;
  assign dmem_we   = dmem_req & dec_is_store;
  assign dmem_addr = r_dmem_addr;
  assign rf_wen    = (r_state == S_WB) & ~rst & dec_reg_write & ~dec_is_store;

  assign inst      = r_inst;
  assign pc        = r_pc;
  assign load_data = r_load_data;
  assign state     = r_state;
  assign halted    = r_halted;
  assign err_code  = r_err_code;

  // A wait cycle is a memory state with the request up and no ready.
  assign w_mem_wait   = ((r_state == S_FETCH) & ~imem_ready) |
                        ((r_state == S_MEM)   & ~dmem_ready);
  assign w_timeout    = w_mem_wait & (r_wait_cnt == C_MAX_WAIT);
  assign w_misaligned = (ex_next_pc[1:0] != 2'b00);

  // Main sequencer: state, PC, instruction register, load data and errors.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_FETCH;
      r_pc        <= RESET_PC;
      r_inst      <= 32'd0;
      r_dmem_addr <= '0;
      r_load_data <= 32'd0;
      r_halted    <= 1'b0;
      r_err_code  <= C_ERR_NONE;
      r_wait_cnt  <= '0;
    end else begin
      case (r_state)
        S_FETCH: begin
          if (imem_ready) begin
            r_inst     <= imem_rdata;
            r_state    <= S_DECODE;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_err_code <= C_ERR_TIMEOUT;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_DECODE: begin
          if (dec_ebreak) begin
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_err_code <= C_ERR_NONE;
          end else begin
            r_state <= S_EXECUTE;
          end
        end
        S_EXECUTE: begin
          r_dmem_addr <= ex_mem_addr;
          r_state     <= (dec_is_load | dec_is_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          if (dmem_ready) begin
            if (dec_is_load) begin
              r_load_data <= dmem_rdata;
            end
            r_state    <= S_WB;
            r_wait_cnt <= '0;
          end else if (w_timeout) begin
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_err_code <= C_ERR_TIMEOUT;
            r_wait_cnt <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        S_WB: begin
          // A misaligned target halts without committing it to the PC.
          if (w_misaligned) begin
            r_state    <= S_HALT;
            r_halted   <= 1'b1;
            r_err_code <= C_ERR_MISALGN;
          end else begin
            r_pc    <= ex_next_pc;
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state  <= S_HALT;
          r_halted <= 1'b1;
        end
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  // Performance counters: active cycles and retired instructions.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_cycles  <= 64'd0;
      perf_instret <= 64'd0;
    end else begin
      if (r_state != S_HALT) begin
        perf_cycles <= perf_cycles + 64'd1;
      end
      if ((r_state == S_WB) && !w_misaligned) begin
        perf_instret <= perf_instret + 64'd1;
      end
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_core_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_core_ctrl
// Purpose  : Randomised self-checking bench for multicycle_core_ctrl. A
//            transaction-level model predicts cycle counts, PC, load data,
//            write strobes and halt/error outcome per instruction.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_multicycle_core_ctrl;

  localparam logic [31:0] C_RST_PC = 32'h8000_0000;
  localparam int          C_MW     = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req, imem_ready = 1'b0;
  logic [31:0] imem_addr, imem_rdata = 32'd0;
  logic [31:0] inst, pc;
  logic        dec_is_load, dec_is_store, dec_reg_write, dec_ebreak;
  logic [31:0] ex_next_pc, ex_mem_addr;
  logic        dmem_req, dmem_we, dmem_ready = 1'b0;
  logic [31:0] dmem_addr, dmem_rdata = 32'd0, load_data;
  logic        rf_wen, halted;
  logic [2:0]  state;
  logic [1:0]  err_code;
`ifdef MC_CTRL_PERF_EN
  logic [63:0] perf_cycles, perf_instret;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] m_pc;
  logic [31:0] m_ld;
  longint      m_ret;

  always #5 clk = ~clk;

  // Datapath stand-in: flags and address arithmetic decoded from inst bits.
  assign dec_is_load   = inst[0];
  assign dec_is_store  = inst[1] & ~inst[0];
  assign dec_reg_write = inst[2];
  assign dec_ebreak    = inst[3];
  assign ex_next_pc    = pc + {26'd0, inst[11:8], 2'b00} + {30'd0, inst[4], 1'b0};
  assign ex_mem_addr   = C_RST_PC + {14'd0, inst[31:16], 2'b00};

  multicycle_core_ctrl #(
    .ADDR_W   (32),
    .RESET_PC (C_RST_PC),
    .MAX_WAIT (C_MW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .inst          (inst),
    .pc            (pc),
    .dec_is_load   (dec_is_load),
    .dec_is_store  (dec_is_store),
    .dec_reg_write (dec_reg_write),
    .dec_ebreak    (dec_ebreak),
    .ex_next_pc    (ex_next_pc),
    .ex_mem_addr   (ex_mem_addr),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_ready    (dmem_ready),
    .dmem_rdata    (dmem_rdata),
    .load_data     (load_data),
    .rf_wen        (rf_wen),
    .state         (state),
    .halted        (halted),
    .err_code      (err_code)
`ifdef MC_CTRL_PERF_EN
    ,
    .perf_cycles   (perf_cycles),
    .perf_instret  (perf_instret)
`endif
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Reset for two cycles, then check the architectural reset state.
  task automatic do_reset();
    rst = 1'b1;
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check("rst_imem_req", 64'(imem_req), 64'd0);
    end
    rst = 1'b0;
    #1;
    check("rst_pc", 64'(pc), 64'(C_RST_PC));
    check("rst_state", 64'(state), 64'd0);
    check("rst_imem_req_after", 64'(imem_req), 64'd1);
    check("rst_flags", 64'({halted, err_code, rf_wen, dmem_req}), 64'd0);
    check("rst_regs", 64'({inst | load_data | dmem_addr}), 64'd0);
`ifdef MC_CTRL_PERF_EN
    check("rst_perf", perf_cycles | perf_instret, 64'd0);
`endif
    m_pc  = C_RST_PC;
    m_ld  = 32'd0;
    m_ret = 0;
  endtask

  // Run one instruction from FETCH with the given memory latencies.
  // Returns 1 if the instruction ended in HALT.
  task automatic run_instr(input logic [31:0] w, input int ilat, input int dlat,
                           input logic [31:0] rd, output bit halt_out);
    logic        ld, st, rw, eb, mis, is_mem;
    logic [31:0] exp_next, exp_maddr;
    int          exp_cyc, n, ic, dc, wen, mreq, ibad, dbad, hbad;
    bit          fin, left;
    ld  = w[0];
    st  = w[1] & ~w[0];
    rw  = w[2];
    eb  = w[3];
    mis = w[4];
    is_mem    = (ld | st) & ~eb;
    exp_next  = m_pc + {26'd0, w[11:8], 2'b00} + (mis ? 32'd2 : 32'd0);
    exp_maddr = C_RST_PC + {14'd0, w[31:16], 2'b00};
    exp_cyc   = (ilat + 1) + 1 + (eb ? 0 : (1 + (is_mem ? dlat + 1 : 0) + 1));
    imem_rdata = w;
    dmem_rdata = rd;
    check("fetch_state", 64'(state), 64'd0);
    check("fetch_addr", 64'(imem_addr), 64'(m_pc));
    n = 0; ic = 0; dc = 0; wen = 0; mreq = 0; ibad = 0; dbad = 0; hbad = 0;
    fin = 1'b0; left = 1'b0;
    while (!fin) begin
      if (rf_wen) wen++;
      if (imem_req && imem_addr !== m_pc) ibad++;
      if (dmem_req) begin
        mreq++;
        if (dmem_addr !== exp_maddr || dmem_we !== st) dbad++;
      end
      imem_ready = imem_req && (ic >= ilat);
      if (imem_req) ic++;
      dmem_ready = dmem_req && (dc >= dlat);
      if (dmem_req) dc++;
      @(negedge clk);
      n++;
      if (state != 3'd0) left = 1'b1;
      if (state == 3'd5 || (left && state == 3'd0)) fin = 1'b1;
      if (n >= 60) fin = 1'b1;
    end
    imem_ready = 1'b0;
    dmem_ready = 1'b0;
    check("cycles", 64'(n), 64'(exp_cyc));
    check("inst", 64'(inst), 64'(w));
    check("imem_addr_stable", 64'(ibad), 64'd0);
    check("dmem_req_cycles", 64'(mreq), 64'(is_mem ? dlat + 1 : 0));
    check("dmem_addr_we", 64'(dbad), 64'd0);
    check("rf_wen_pulses", 64'(wen), 64'((!eb && rw && !st) ? 1 : 0));
    if (ld && !eb) m_ld = rd;
    check("load_data", 64'(load_data), 64'(m_ld));
    halt_out = eb | mis;
    if (halt_out) begin
      check("halt_state", 64'(state), 64'd5);
      check("halted", 64'(halted), 64'd1);
      check("err_code", 64'(err_code), eb ? 64'd0 : 64'd2);
      check("halt_pc", 64'(pc), 64'(m_pc));
      imem_ready = 1'b1;
      dmem_ready = 1'b1;
      repeat (3) begin
        @(negedge clk);
        if (imem_req || dmem_req || rf_wen || state != 3'd5) hbad++;
      end
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      check("halt_absorbing", 64'(hbad), 64'd0);
    end else begin
      m_pc = exp_next;
      m_ret++;
      check("next_pc", 64'(pc), 64'(m_pc));
      check("no_err", 64'({halted, err_code}), 64'd0);
    end
`ifdef MC_CTRL_PERF_EN
    check("perf_instret", perf_instret, 64'(m_ret));
`endif
  endtask

  initial begin
    bit          h;
    int          n, bad;
    logic [31:0] w;
    @(negedge clk);
    do_reset();

    // ALU op, zero wait, PC+4
    run_instr(32'h0000_0104, 0, 0, 32'd0, h);
    // Load with 3 wait cycles at 8000_0100
    run_instr(32'h0040_0105, 0, 3, 32'hDEAD_BEEF, h);
    // Store with fetch waits
    run_instr(32'h0012_0106, 2, 1, 32'h1234_5678, h);
    // Misaligned next PC
    run_instr(32'h0000_0014, 0, 0, 32'd0, h);
    do_reset();
    // ebreak
    run_instr(32'h0000_000C, 1, 0, 32'd0, h);
    do_reset();

    // Fetch timeout with imem_ready stuck low
    n = 0;
    while (state != 3'd5 && n < 20) begin
      if (imem_req) n++;
      @(negedge clk);
    end
    check("timeout_fetch_cycles", 64'(n), 64'(C_MW + 1));
    check("timeout_err", 64'({halted, err_code}), 64'({1'b1, 2'd1}));
    bad = 0;
    repeat (3) begin
      if (imem_req || dmem_req) bad++;
      @(negedge clk);
    end
    check("timeout_no_req", 64'(bad), 64'd0);
    do_reset();

    // Reset while a store is in MEM with ready arriving at the same edge
    imem_rdata = 32'h0003_0106;
    imem_ready = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 20) begin
      @(negedge clk);
      if (state != 3'd0) imem_ready = 1'b0;
      n++;
    end
    check("reach_mem", 64'(state), 64'd3);
    rst = 1'b1;
    dmem_ready = 1'b1;
    @(negedge clk);
    check("midrst_dmem_req", 64'(dmem_req), 64'd0);
    check("midrst_rf_wen", 64'(rf_wen), 64'd0);
    check("midrst_pc", 64'(pc), 64'(C_RST_PC));
    do_reset();
    repeat (3) run_instr(32'h0000_0104, 0, 0, 32'd0, h);
`ifdef MC_CTRL_PERF_EN
    check("perf_instret_three", perf_instret, 64'd3);
`endif

    // Randomised instruction stream
    for (int i = 0; i < 60; i++) begin
      int kind;
      kind = int'($urandom_range(0, 11));
      w = $urandom;
      w[3] = (kind == 0);
      w[4] = (kind == 1);
      run_instr(w, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), $urandom, h);
      if (h) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
